// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Definitions shared by the LCD timing counters:
//   LCD_CNT_WIDTH            default count width (20 bits)
//   LCD_DIR_UP, LCD_DIR_DOWN values of the 'up' input for each direction
//   clog2()                  bit width needed to hold values 0..n-1
// ----------------------------------------------------------------------------
package lcd_pkg;

    localparam int unsigned LCD_CNT_WIDTH = 20;

    localparam logic LCD_DIR_UP   = 1'b1;
    localparam logic LCD_DIR_DOWN = 1'b0;

    // Number of bits needed to hold the values 0..n-1. Never returns less
    // than 1, so a degenerate prescaler still has a legal register width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : lcd_pkg

// File: rtl/lcd_prescaler.sv
// ----------------------------------------------------------------------------
// lcd_prescaler
// Divides enabled clock cycles by PRESCALE. 'step' is high in the enabled
// cycle that completes a group of PRESCALE enabled cycles.
// Parameters:
//   PRESCALE  clk cycles per step while enabled (>=1)
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high reset, sets the phase to 0
//   clear   in   synchronous phase restart (counter clear or load)
//   enable  in   the phase advances only while high; holds otherwise
//   step    out  combinational step qualifier for the owning counter
// ----------------------------------------------------------------------------
module lcd_prescaler
    import lcd_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic step
);

    localparam int unsigned PW = clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_TERM = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // Step qualifier. With PRESCALE==1 the phase stays at 0, so step follows enable.
    always_comb begin
        step = enable && (pre_q == PRE_TERM);
    end

    // Phase next-state: restart on clear, wrap on step, advance while enabled.
    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = {PW{1'b0}};
        end else if (step) begin
            pre_d = {PW{1'b0}};
        end else if (enable) begin
            pre_d = pre_q + PW'(1);
        end else begin
            pre_d = pre_q;
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= {PW{1'b0}};
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule : lcd_prescaler

// File: rtl/lcd_mod_counter.sv
// ----------------------------------------------------------------------------
// lcd_mod_counter
// Modulo counter for LCD timing (pixel / line / frame positions). It counts
// 0..limit up or down, steps once every PRESCALE enabled cycles, and emits a
// registered one-cycle 'wrap' pulse so instances can be chained.
// Parameters:
//   WIDTH      count width (>=2)
//   PRESCALE   clk cycles per step while enabled (>=1)
//   RESET_VAL  count value after reset
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   clear      in   synchronous clear: count and prescaler to 0
//   enable     in   count steps only when high
//   up         in   1 = up, 0 = down
//   load       in   synchronous load of load_val (restarts the prescaler)
//   load_val   in   value to load
//   limit      in   terminal value, count range 0..limit
//   count      out  registered count
//   wrap       out  registered one-cycle pulse on each wrap
// Optional feature, macro LCD_COUNTER_MATCH_EN:
//   match_val  in   compare value
//   match      out  registered pulse when an update (step, load or clear)
//                   leaves the count equal to match_val
// Update priority per edge: reset > clear > load > step > hold.
// ----------------------------------------------------------------------------
module lcd_mod_counter
    import lcd_pkg::*;
#(
    parameter int unsigned WIDTH     = LCD_CNT_WIDTH,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap
`ifdef LCD_COUNTER_MATCH_EN
    ,
    input  logic [WIDTH-1:0] match_val,
    output logic             match
`endif
);

    localparam logic [WIDTH-1:0] CNT_RESET = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};

    logic             step_s;
    logic             pre_clear_s;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;

    // Load restarts the prescaler just like clear does.
    always_comb begin
        pre_clear_s = clear || load;
    end

    lcd_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (pre_clear_s),
        .enable (enable),
        .step   (step_s)
    );

    // Count next-state. A count above limit (left by a load or a shrinking
    // limit) is treated as past the boundary in both directions.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clear) begin
            cnt_d = CNT_ZERO;
        end else if (load) begin
            cnt_d = load_val;
        end else if (step_s) begin
            if (up == LCD_DIR_UP) begin
                if (cnt_q >= limit) begin
                    cnt_d  = CNT_ZERO;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if ((cnt_q == CNT_ZERO) || (cnt_q > limit)) begin
                    cnt_d  = limit;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count and wrap registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= CNT_RESET;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign count = cnt_q;
    assign wrap  = wrap_q;

`ifdef LCD_COUNTER_MATCH_EN
    logic match_q;
    logic match_d;

    // Match fires on any update event, even one that reloads the same value.
    always_comb begin
        if ((clear || load || step_s) && (cnt_d == match_val)) begin
            match_d = 1'b1;
        end else begin
            match_d = 1'b0;
        end
    end

    // Match register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`endif

endmodule : lcd_mod_counter

// File: tb/tb_lcd_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_lcd_mod_counter
// Two instances share one set of inputs: u1 (WIDTH=4, PRESCALE=1,
// RESET_VAL=0) and u3 (WIDTH=4, PRESCALE=3, RESET_VAL=1). A behavioural
// model tracks both on every edge; a vector table and hand-written
// sequences cover the documented corner cases, followed by random stimulus.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_mod_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       enable;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] limit;
    logic [3:0] match_val;
    logic [3:0] count1;
    logic [3:0] count3;
    logic       wrap1;
    logic       wrap3;
`ifdef LCD_COUNTER_MATCH_EN
    logic       match1;
    logic       match3;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    lcd_mod_counter #(.WIDTH(4), .PRESCALE(1), .RESET_VAL(0)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up(up),
        .load(load), .load_val(load_val), .limit(limit),
        .count(count1), .wrap(wrap1)
`ifdef LCD_COUNTER_MATCH_EN
        , .match_val(match_val), .match(match1)
`endif
    );

    lcd_mod_counter #(.WIDTH(4), .PRESCALE(3), .RESET_VAL(1)) u3 (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up(up),
        .load(load), .load_val(load_val), .limit(limit),
        .count(count3), .wrap(wrap3)
`ifdef LCD_COUNTER_MATCH_EN
        , .match_val(match_val), .match(match3)
`endif
    );

    // ---------------- reference model ----------------
    int m_cnt[2];
    int m_pre[2];
    int m_wrap[2];
    int m_match[2];

    function automatic int presc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int rval(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = rval(k); m_pre[k] = 0; m_wrap[k] = 0; m_match[k] = 0;
        end
    endtask

    // Range 0..L is a ring of L+1 positions; values above L are off the ring.
    task automatic model_edge();
        int lim;
        lim = int'(limit);
        for (int k = 0; k < 2; k++) begin
            m_wrap[k]  = 0;
            m_match[k] = 0;
            if (reset) begin
                m_cnt[k] = rval(k); m_pre[k] = 0;
            end else if (clear) begin
                m_cnt[k] = 0; m_pre[k] = 0;
                m_match[k] = (int'(match_val) == 0) ? 1 : 0;
            end else if (load) begin
                m_cnt[k] = int'(load_val); m_pre[k] = 0;
                m_match[k] = (int'(load_val) == int'(match_val)) ? 1 : 0;
            end else if (enable) begin
                m_pre[k] = m_pre[k] + 1;
                if (m_pre[k] == presc(k)) begin
                    m_pre[k] = 0;
                    if (up) begin
                        if (m_cnt[k] > lim) m_cnt[k] = 0;
                        else m_cnt[k] = (m_cnt[k] + 1) % (lim + 1);
                        m_wrap[k] = (m_cnt[k] == 0) ? 1 : 0;
                    end else begin
                        if (m_cnt[k] > lim || m_cnt[k] == 0) begin
                            m_cnt[k] = lim; m_wrap[k] = 1;
                        end else begin
                            m_cnt[k] = (m_cnt[k] + lim) % (lim + 1);
                        end
                    end
                    m_match[k] = (m_cnt[k] == int'(match_val)) ? 1 : 0;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge: advance the model, then compare both instances.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("u1.count model", int'(count1), m_cnt[0]);
        chk("u1.wrap model",  int'(wrap1),  m_wrap[0]);
        chk("u3.count model", int'(count3), m_cnt[1]);
        chk("u3.wrap model",  int'(wrap3),  m_wrap[1]);
`ifdef LCD_COUNTER_MATCH_EN
        chk("u1.match model", int'(match1), m_match[0]);
        chk("u3.match model", int'(match3), m_match[1]);
`endif
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic u,
                         input logic [3:0] lv, input logic [3:0] lim);
        clear = c; load = l; enable = e; up = u; load_val = lv; limit = lim;
    endtask

    typedef struct {
        logic       clr;
        logic       ld;
        logic       en;
        logic       dir;
        logic [3:0] lv;
        logic [3:0] lim;
        logic [3:0] exp_cnt;
        logic       exp_wrap;
    } vec_t;

    vec_t tv[$];
    int   laps;

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5);
        match_val = 4'd15;
        model_reset();

        // Vectors for u1 (PRESCALE=1); expected values are after the edge.
        for (int k = 1; k <= 5; k++)
            tv.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 4'(k), 1'b0});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 4'd0, 1'b1});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 4'd1, 1'b0});
        // down, limit 3: load 1, then 0, then wrap to 3; load 9 > limit
        tv.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd3, 4'd1, 1'b0});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 1'b0});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd3, 1'b1});
        tv.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 4'd3, 4'd9, 1'b0});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd3, 1'b1});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd2, 1'b0});
        // clear+load+enable together, then limit 0
        tv.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'd3, 4'd0, 1'b0});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1});
        // load above limit counting up, hold, limit shrunk mid-count
        tv.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 4'd5, 4'd8, 1'b0});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 4'd0, 1'b1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5, 4'd0, 1'b0});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 4'd1, 1'b0});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 4'd0, 1'b1});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset u1.count", int'(count1), 0);
        chk("reset u1.wrap",  int'(wrap1),  0);
        chk("reset u3.count", int'(count3), 1);
        chk("reset u3.wrap",  int'(wrap3),  0);
        reset = 1'b0;

        // Table
        foreach (tv[i]) begin
            drive(tv[i].clr, tv[i].ld, tv[i].en, tv[i].dir, tv[i].lv, tv[i].lim);
            tick();
            chk($sformatf("vec%0d count", i), int'(count1), int'(tv[i].exp_cnt));
            chk($sformatf("vec%0d wrap", i),  int'(wrap1),  int'(tv[i].exp_wrap));
        end

        // PRESCALE=3, limit 2, with a 4-cycle enable gap
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2);
        tick(); tick();
        chk("presc no step yet", int'(count3), 0);
        tick();
        chk("presc 1st step", int'(count3), 1);
        tick(); tick(); tick();
        chk("presc 2nd step", int'(count3), 2);
        tick();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("presc hold count", int'(count3), 2);
        end
        enable = 1'b1;
        tick();
        chk("presc resume no step", int'(count3), 2);
        tick();
        chk("presc resume wrap count", int'(count3), 0);
        chk("presc resume wrap", int'(wrap3), 1);

        // Asynchronous reset between edges at count 4
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5);
        repeat (4) tick();
        chk("pre-reset u1.count", int'(count1), 4);
        #2 reset = 1'b1;
        #1;
        chk("async reset u1.count", int'(count1), 0);
        chk("async reset u1.wrap",  int'(wrap1),  0);
        chk("async reset u3.count", int'(count3), 1);
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        chk("post-reset u1 step", int'(count1), 1);
        chk("post-reset u3 wait1", int'(count3), 1);
        tick();
        chk("post-reset u3 wait2", int'(count3), 1);
        tick();
        chk("post-reset u3 step", int'(count3), 2);

`ifdef LCD_COUNTER_MATCH_EN
        match_val = 4'd3;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5);
        laps = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (match1 && count1 == 4'd3) laps++;
        end
        chk("match per lap", laps, 2);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5);
        repeat (3) tick();
        chk("match at 3", int'(match1), 1);
        enable = 1'b0;
        tick();
        chk("match hold 1", int'(match1), 0);
        tick();
        chk("match hold 2", int'(match1), 0);
        load = 1'b1; load_val = 4'd3;
        tick();
        chk("match on load", int'(match1), 1);
        load = 1'b0;
`endif

        // Random stimulus against the model
        for (int i = 0; i < 500; i++) begin
            clear     = ($urandom_range(15, 0) == 0);
            load      = ($urandom_range(7, 0) == 0);
            enable    = ($urandom_range(3, 0) != 0);
            up        = 1'($urandom_range(1, 0));
            load_val  = 4'($urandom_range(15, 0));
            match_val = 4'($urandom_range(15, 0));
            if ($urandom_range(15, 0) == 0) limit = 4'($urandom_range(15, 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_lcd_mod_counter
